address_offset_unit: RTL
========================

Name: address_offset_unit

Overview:
- Multi-channel, multi-thread operand address offsetter. Next generation of the per-thread offset adder.
- Adds a per-thread offset to CHANNEL_COUNT operand addresses in parallel, typically A, B and D operands. The offset is a programmed post-incrementing offset for indirect memory, zero for shared memory, or a per-thread default offset for direct memory.
- New relative to the previous generation: signed increments, per-channel offset banks, asynchronously resettable state, and defined write/increment collision rules.
- Sits between instruction decode and the data memories. Fixed 2-cycle latency.

Parameters:
- ADDR_WIDTH, 10, width of operand addresses and offsets.
- CHANNEL_COUNT, 3, number of operand channels processed in parallel.
- THREAD_COUNT, 8, number of round-robin threads; must be >= 3.
- THREAD_COUNT_WIDTH, 3, clog2(THREAD_COUNT).
- PO_ENTRY_COUNT, 4, programmed offset entries per thread per channel.
- PO_ADDR_WIDTH, 2, clog2(PO_ENTRY_COUNT).
- PO_INCR_WIDTH, 4, signed two's-complement increment width.
- Localparam PO_ENTRY_WIDTH = PO_INCR_WIDTH + ADDR_WIDTH, laid out as {incr, offset}.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- raw_addr  in  CHANNEL_COUNT*ADDR_WIDTH  operand addresses; channel c occupies slice c.
- shared  in  CHANNEL_COUNT  per-channel flag: address decodes to shared memory.
- indirect  in  CHANNEL_COUNT  per-channel flag: address decodes to indirect memory (indirect overrides shared).
- io_ready_current  in  1  current instruction not annulled; aligned with offset_addr output.
- cancel_current  in  1  current instruction cancelled; aligned with offset_addr output.
- io_ready_previous  in  1  gating for external writes; aligned with the write ports.
- cancel_previous  in  1  gating for external writes; aligned with the write ports.
- po_wren  in  1  programmed offset write enable.
- po_write_channel  in  clog2(CHANNEL_COUNT)  target channel bank.
- po_write_addr  in  PO_ADDR_WIDTH  target entry.
- po_write_data  in  PO_ENTRY_WIDTH  {incr, offset}.
- do_wren  in  1  default offset write enable.
- do_write_channel  in  clog2(CHANNEL_COUNT)  target channel.
- do_write_data  in  ADDR_WIDTH  default offset value.
- offset_addr  out  CHANNEL_COUNT*ADDR_WIDTH  offset addresses, registered.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - offset_addr, all PO entries and all DO entries clear to 0.
  - read_thread clears to 0; write_thread clears to THREAD_COUNT-2 (mod THREAD_COUNT).
  - Stage valid bits clear.
  - Reset asserted mid-operation drops all in-flight increments and writes.
- Thread counters: read_thread increments every cycle and wraps at THREAD_COUNT-1 to 0. write_thread equals read_thread - 2 (mod THREAD_COUNT), i.e. the thread whose result is currently on offset_addr.
- Stage 0, cycle N:
  - Register raw_addr, shared and indirect.
  - Read DO[read_thread][c] and PO[read_thread][c][raw_addr_c[PO_ADDR_WIDTH-1:0]].
  - Record the selected entry index.
  - Set valid.
- Stage 1, cycle N+1:
  - Per channel, final offset = PO.offset if indirect; else 0 if shared; else DO.
  - offset_addr_c <= raw_addr_c + final offset, modulo 2^ADDR_WIDTH. Output is visible during cycle N+2.
- Post-increment, end of cycle N+2:
  - Applies per channel when indirect, valid, io_ready_current=1 and cancel_current=0.
  - PO[write_thread][c][idx].offset <= offset + sign-extended incr, modulo 2^ADDR_WIDTH.
  - The incr field is unchanged.
  - Otherwise the entry holds its value.
- External writes (cycle N+2 alignment, target thread = write_thread):
  - A write takes effect only when io_ready_previous=1 and cancel_previous=0.
  - A write with po_write_channel or do_write_channel >= CHANNEL_COUNT is ignored.
- Collision: an external PO write and a post-increment to the same thread, channel and entry in the same cycle: the external write wins completely and the increment is discarded. Different entries or channels: both take effect.
- Visibility: THREAD_COUNT >= 3 guarantees a thread's next read sees its own updates. No bypass logic.
- First two cycles after reset: no increments, because the stages are not yet valid.

Decomposition:
- Shared package address_offset_pkg holds:
  - PO entry field offsets;
  - the sign-extension function;
  - ZERO_OFFSET;
  - the PIPE_DEPTH=2 constant.
- One sub-module, address_offset_channel, instantiated CHANNEL_COUNT times. It holds one channel's PO/DO register banks, offset selection, adder and increment/write arbitration.
- Thread counters live in the top level and are shared by all channels.

Test Plan:
- Reset then release; thread 0, channel 0 direct, raw 0x005 -> offset_addr[0]=0x005 two cycles later; all outputs 0 during reset.
- DO write of 0x100 for thread 3, channel 1. Thread 3, channel 1 direct raw 0x020 -> 0x120. Same with shared=1 -> 0x020.
- PO thread 0, channel 0, entry 2 = {incr=+1, offset=0x200}. Three thread-0 indirect raw 0x002 accesses -> 0x202, 0x203, 0x204.
- Entry {incr=4'hE (-2), offset=0x001}, raw 0x002 -> 0x003, then 0x001 (offset wrapped to 0x3FF).
- Same as the +1 case with cancel_current=1 on the second access -> outputs 0x202, 0x203, 0x203. Repeat with io_ready_current=0 -> same result.
- External PO write of {+1, 0x050} colliding with the increment of the same entry -> next access 0x052. Write with cancel_previous=1 -> ignored.

Source files
------------

// File: rtl/address_offset_pkg.sv
// Shared constants and helpers for the per-thread operand address offsetter.
// PO entries are packed {incr, offset}, with offset in the low ADDR_WIDTH bits.
package address_offset_pkg;

  localparam int PIPE_DEPTH    = 2;
  localparam int PO_OFFSET_LSB = 0;
  localparam logic [31:0] ZERO_OFFSET = '0;

  // incr sits directly above the offset field
  function automatic int po_incr_lsb(input int addr_width);
    return PO_OFFSET_LSB + addr_width;
  endfunction

  function automatic int sel_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // Sign-extend the low 'width' bits of value to 32 bits
  function automatic logic [31:0] sign_extend(input logic [31:0] value, input int width);
    logic [31:0] shifted;
    shifted = value << (32 - width);
    return 32'($signed(shifted) >>> (32 - width));
  endfunction

endpackage

// File: rtl/address_offset_if.sv
// Operand bus between decode and the offsetter: raw addresses, decode flags,
// annul/cancel qualifiers, offset-bank write ports and the offset result.
interface address_offset_if
  import address_offset_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int CHANNEL_COUNT = 3,
  parameter int PO_ADDR_WIDTH = 2,
  parameter int PO_INCR_WIDTH = 4
);
  localparam int PO_ENTRY_WIDTH = PO_INCR_WIDTH + ADDR_WIDTH;
  localparam int CH_SEL_WIDTH   = sel_width(CHANNEL_COUNT);

  logic [CHANNEL_COUNT*ADDR_WIDTH-1:0] raw_addr;
  logic [CHANNEL_COUNT-1:0]            shared;
  logic [CHANNEL_COUNT-1:0]            indirect;
  logic                                io_ready_current;
  logic                                cancel_current;
  logic                                io_ready_previous;
  logic                                cancel_previous;
  logic                                po_wren;
  logic [CH_SEL_WIDTH-1:0]             po_write_channel;
  logic [PO_ADDR_WIDTH-1:0]            po_write_addr;
  logic [PO_ENTRY_WIDTH-1:0]           po_write_data;
  logic                                do_wren;
  logic [CH_SEL_WIDTH-1:0]             do_write_channel;
  logic [ADDR_WIDTH-1:0]               do_write_data;
  logic [CHANNEL_COUNT*ADDR_WIDTH-1:0] offset_addr;

  modport master (
    output raw_addr, shared, indirect, io_ready_current, cancel_current,
           io_ready_previous, cancel_previous, po_wren, po_write_channel,
           po_write_addr, po_write_data, do_wren, do_write_channel, do_write_data,
    input  offset_addr
  );

  modport slave (
    input  raw_addr, shared, indirect, io_ready_current, cancel_current,
           io_ready_previous, cancel_previous, po_wren, po_write_channel,
           po_write_addr, po_write_data, do_wren, do_write_channel, do_write_data,
    output offset_addr
  );

endinterface

// File: rtl/address_offset_channel.sv
// One operand channel: PO/DO banks, offset select, adder, post-increment vs write arbitration.
// Latency 2 cycles; no backpressure, a result is produced every cycle.
module address_offset_channel
  import address_offset_pkg::*;
#(
  parameter int ADDR_WIDTH         = 10,
  parameter int THREAD_COUNT       = 8,
  parameter int THREAD_COUNT_WIDTH = 3,
  parameter int PO_ENTRY_COUNT     = 4,
  parameter int PO_ADDR_WIDTH      = 2,
  parameter int PO_INCR_WIDTH      = 4,
  localparam int PO_ENTRY_WIDTH    = PO_INCR_WIDTH + ADDR_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [THREAD_COUNT_WIDTH-1:0] read_thread,
  input  logic [THREAD_COUNT_WIDTH-1:0] write_thread,
  input  logic [ADDR_WIDTH-1:0]         raw_addr,
  input  logic                          shared,
  input  logic                          indirect,
  input  logic                          io_ready_current,
  input  logic                          cancel_current,
  input  logic                          po_wren,
  input  logic [PO_ADDR_WIDTH-1:0]      po_write_addr,
  input  logic [PO_ENTRY_WIDTH-1:0]     po_write_data,
  input  logic                          do_wren,
  input  logic [ADDR_WIDTH-1:0]         do_write_data,
  output logic [ADDR_WIDTH-1:0]         offset_addr
);

  localparam int INCR_LSB = po_incr_lsb(ADDR_WIDTH);

  logic [PO_ENTRY_WIDTH-1:0] po_mem [THREAD_COUNT][PO_ENTRY_COUNT];
  logic [ADDR_WIDTH-1:0]     do_mem [THREAD_COUNT];

  logic                     s0_valid, s0_shared, s0_indirect;
  logic [ADDR_WIDTH-1:0]    s0_raw, s0_do, s0_po;
  logic [PO_ADDR_WIDTH-1:0] s0_idx;
  logic                     s1_valid, s1_indirect;
  logic [PO_ADDR_WIDTH-1:0] s1_idx;

  logic [PO_ADDR_WIDTH-1:0]  rd_idx;
  logic [ADDR_WIDTH-1:0]     sel_offset;
  logic [PO_ENTRY_WIDTH-1:0] inc_entry;
  logic [ADDR_WIDTH-1:0]     inc_offset;
  logic                      inc_en;

  assign rd_idx = raw_addr[PO_ADDR_WIDTH-1:0];

  always_comb begin
    sel_offset = s0_do;
    if (s0_indirect)
      sel_offset = s0_po;
    else if (s0_shared)
      sel_offset = ADDR_WIDTH'(ZERO_OFFSET);
  end

  // write_thread is the thread whose result is on offset_addr this cycle
  assign inc_entry  = po_mem[write_thread][s1_idx];
  assign inc_offset = inc_entry[PO_OFFSET_LSB +: ADDR_WIDTH]
                    + ADDR_WIDTH'(sign_extend(32'(inc_entry[INCR_LSB +: PO_INCR_WIDTH]), PO_INCR_WIDTH));
  assign inc_en     = s1_valid & s1_indirect & io_ready_current & ~cancel_current;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s0_valid    <= 1'b0;
      s0_shared   <= 1'b0;
      s0_indirect <= 1'b0;
      s0_raw      <= '0;
      s0_do       <= '0;
      s0_po       <= '0;
      s0_idx      <= '0;
      s1_valid    <= 1'b0;
      s1_indirect <= 1'b0;
      s1_idx      <= '0;
      offset_addr <= '0;
    end else begin
      s0_valid    <= 1'b1;
      s0_shared   <= shared;
      s0_indirect <= indirect;
      s0_raw      <= raw_addr;
      s0_do       <= do_mem[read_thread];
      s0_po       <= po_mem[read_thread][rd_idx][PO_OFFSET_LSB +: ADDR_WIDTH];
      s0_idx      <= rd_idx;
      s1_valid    <= s0_valid;
      s1_indirect <= s0_indirect;
      s1_idx      <= s0_idx;
      offset_addr <= s0_raw + sel_offset;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int t = 0; t < THREAD_COUNT; t++) begin
        do_mem[t] <= '0;
        for (int e = 0; e < PO_ENTRY_COUNT; e++)
          po_mem[t][e] <= '0;
      end
    end else begin
      if (inc_en)
        po_mem[write_thread][s1_idx][PO_OFFSET_LSB +: ADDR_WIDTH] <= inc_offset;
      // Issued after the increment so an external write to the same entry replaces it whole
      if (po_wren)
        po_mem[write_thread][po_write_addr] <= po_write_data;
      if (do_wren)
        do_mem[write_thread] <= do_write_data;
    end
  end

endmodule

// File: rtl/address_offset_unit.sv
// Multi-channel per-thread operand address offsetter with shared round-robin thread counters.
// Latency 2 cycles; no backpressure, one result per cycle on every channel.
module address_offset_unit
  import address_offset_pkg::*;
#(
  parameter int ADDR_WIDTH         = 10,
  parameter int CHANNEL_COUNT      = 3,
  parameter int THREAD_COUNT       = 8,
  parameter int THREAD_COUNT_WIDTH = 3,
  parameter int PO_ENTRY_COUNT     = 4,
  parameter int PO_ADDR_WIDTH      = 2,
  parameter int PO_INCR_WIDTH      = 4
) (
  input logic             clock,
  input logic             reset_n,
  address_offset_if.slave bus
);

  localparam int CH_SEL_WIDTH = sel_width(CHANNEL_COUNT);
  localparam logic [THREAD_COUNT_WIDTH-1:0] LAST_THREAD  = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);
  localparam logic [THREAD_COUNT_WIDTH-1:0] WRITE_RESET  = THREAD_COUNT_WIDTH'(THREAD_COUNT - PIPE_DEPTH);

  logic [THREAD_COUNT_WIDTH-1:0] read_thread, write_thread;
  logic                          write_ok;
  logic [CHANNEL_COUNT-1:0]      po_wren_ch, do_wren_ch;
  logic [ADDR_WIDTH-1:0]         ch_offset [CHANNEL_COUNT];

  // write_thread trails read_thread by the pipeline depth
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_thread  <= '0;
      write_thread <= WRITE_RESET;
    end else begin
      read_thread  <= (read_thread  == LAST_THREAD) ? '0 : read_thread  + 1'b1;
      write_thread <= (write_thread == LAST_THREAD) ? '0 : write_thread + 1'b1;
    end
  end

  assign write_ok = bus.io_ready_previous & ~bus.cancel_previous;

  always_comb begin
    po_wren_ch = '0;
    do_wren_ch = '0;
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      po_wren_ch[c] = bus.po_wren & write_ok & (bus.po_write_channel == CH_SEL_WIDTH'(c));
      do_wren_ch[c] = bus.do_wren & write_ok & (bus.do_write_channel == CH_SEL_WIDTH'(c));
    end
  end

  always_comb begin
    bus.offset_addr = '0;
    for (int c = 0; c < CHANNEL_COUNT; c++)
      bus.offset_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = ch_offset[c];
  end

  for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_ch
    address_offset_channel #(
      .ADDR_WIDTH         (ADDR_WIDTH),
      .THREAD_COUNT       (THREAD_COUNT),
      .THREAD_COUNT_WIDTH (THREAD_COUNT_WIDTH),
      .PO_ENTRY_COUNT     (PO_ENTRY_COUNT),
      .PO_ADDR_WIDTH      (PO_ADDR_WIDTH),
      .PO_INCR_WIDTH      (PO_INCR_WIDTH)
    ) u_channel (
      .clock            (clock),
      .reset_n          (reset_n),
      .read_thread      (read_thread),
      .write_thread     (write_thread),
      .raw_addr         (bus.raw_addr[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .shared           (bus.shared[c]),
      .indirect         (bus.indirect[c]),
      .io_ready_current (bus.io_ready_current),
      .cancel_current   (bus.cancel_current),
      .po_wren          (po_wren_ch[c]),
      .po_write_addr    (bus.po_write_addr),
      .po_write_data    (bus.po_write_data),
      .do_wren          (do_wren_ch[c]),
      .do_write_data    (bus.do_write_data),
      .offset_addr      (ch_offset[c])
    );
  end

endmodule
